// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Bundle of the fetch controller's bus signals: the PC register
//               port, the redirect input from execute, the instruction-memory
//               request/response channel and the decode hand-off.
//               master - the fetch controller
//               slave  - the environment (PC register, imem, execute, decode)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
  // PC register
  logic [31:0] pc_output;        // current PC
  logic [31:0] pc_input;         // next PC
  logic        pc_enable;        // PC load enable
  // Redirect from execute
  logic        redirect_valid;
  logic [31:0] redirect_target;
  // Instruction-memory request
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  // Instruction-memory response (never back-pressured)
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  // Decode hand-off
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  modport master (
    input  pc_output,
    output pc_input,
    output pc_enable,
    input  redirect_valid,
    input  redirect_target,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output dec_valid,
    input  dec_ready,
    output dec_instr,
    output dec_pc
  );

  modport slave (
    output pc_output,
    input  pc_input,
    input  pc_enable,
    output redirect_valid,
    output redirect_target,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  dec_valid,
    output dec_ready,
    input  dec_instr,
    input  dec_pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction fetch controller. Issues at most one outstanding
//               instruction-memory request, advances the PC by 4 on each
//               accepted request, queues {pc, instr} in a 2-entry in-order
//               FIFO for decode, and handles redirects by reloading the PC,
//               flushing the FIFO and discarding any in-flight response.
// Ports       : clock - rising-edge clock
//               reset - synchronous, active-high reset
//               bus   - fetch_ctrl_if.master (PC register, redirect, imem
//                       request/response, decode hand-off)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl (
  input  wire logic    clock,
  input  wire logic    reset,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,  // may issue a request
    ST_WAIT  = 2'd1,  // one request outstanding
    ST_DRAIN = 2'd2   // outstanding response will be discarded
  } state_e;

  localparam logic [1:0] FIFO_FULL = 2'd2;

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [63:0] entry_q [2];      // {pc, instr}; entry 0 is the head
  logic [63:0] entry_d [2];
  logic [31:0] req_pc_q, req_pc_d;

  logic        req_valid;
  logic        req_fire;
  logic        push;
  logic        pop;
  logic        pc_enable;
  logic [31:0] pc_input;
  logic [63:0] push_data;

  // A request is only issued from REQ, where nothing is outstanding, so the
  // FIFO count alone guarantees room for the response.
  assign req_valid = !reset && (state_q == ST_REQ) && (count_q != FIFO_FULL)
                     && !bus.redirect_valid;
  assign req_fire  = req_valid && bus.imem_req_ready;
  // A pop coinciding with a redirect is swallowed by the flush.
  assign pop       = !reset && (count_q != 2'd0) && bus.dec_ready
                     && !bus.redirect_valid;
  assign push_data = {req_pc_q, bus.imem_rsp_data};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    entry_d   = entry_q;
    req_pc_d  = req_pc_q;
    push      = 1'b0;
    pc_enable = 1'b0;
    pc_input  = bus.pc_output;

    if (bus.redirect_valid) begin
      pc_enable = 1'b1;
      pc_input  = {bus.redirect_target[31:2], 2'b00};
      count_d   = 2'd0;
      unique case (state_q)
        ST_WAIT:  state_d = bus.imem_rsp_valid ? ST_REQ : ST_DRAIN;
        // A response landing together with the redirect is the one being
        // drained; staying in DRAIN would wait for a response that never comes.
        ST_DRAIN: state_d = bus.imem_rsp_valid ? ST_REQ : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (req_fire) begin
            req_pc_d  = bus.pc_output;
            state_d   = ST_WAIT;
            pc_enable = 1'b1;
            pc_input  = bus.pc_output + 32'd4;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            push    = 1'b1;
            state_d = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (bus.imem_rsp_valid) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase

      unique case ({push, pop})
        2'b10: begin
          entry_d[count_q[0]] = push_data;
          count_d             = count_q + 2'd1;
        end
        2'b01: begin
          entry_d[0] = entry_q[1];
          count_d    = count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: shift and append, count unchanged.
          if (count_q == 2'd1) begin
            entry_d[0] = push_data;
          end else begin
            entry_d[0] = entry_q[1];
            entry_d[1] = push_data;
          end
        end
        default: ;
      endcase
    end

    if (reset) begin
      pc_enable = 1'b0;
      pc_input  = bus.pc_output;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_REQ;
      count_q    <= 2'd0;
      req_pc_q   <= 32'd0;
      entry_q[0] <= 64'd0;
      entry_q[1] <= 64'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      req_pc_q   <= req_pc_d;
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = bus.pc_output;
  assign bus.pc_enable      = pc_enable;
  assign bus.pc_input       = pc_input;
  assign bus.dec_valid      = !reset && (count_q != 2'd0);
  assign bus.dec_pc         = entry_q[0][63:32];
  assign bus.dec_instr      = entry_q[0][31:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. Models the PC register and
//               an instruction memory (word = {addr[15:0]^16'hBEEF, 16'hC0DE},
//               programmable latency). Expected decode entries are queued by
//               the stimulus and checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  logic clock;
  logic reset;
  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  int          rsp_lat = 1;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic check32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic samp();
    @(negedge clock);
  endtask

  // PC register: loads pc_input when pc_enable, clears on reset.
  initial begin
    logic        en, r;
    logic [31:0] nx;
    bus.pc_output = 32'd0;
    forever begin
      @(posedge clock);
      en = bus.pc_enable;
      nx = bus.pc_input;
      r  = reset;
      #1;
      if (r) bus.pc_output = 32'd0;
      else if (en) bus.pc_output = nx;
    end
  end

  // Instruction memory: responds rsp_lat cycles after an accepted request.
  initial begin
    logic        hs;
    logic [31:0] a;
    logic [31:0] pend_addr;
    int          pend_cnt;
    pend_cnt           = 0;
    pend_addr          = 32'd0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    forever begin
      @(posedge clock);
      hs = bus.imem_req_valid && bus.imem_req_ready;
      a  = bus.imem_req_addr;
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (hs) begin
        pend_addr = a;
        pend_cnt  = rsp_lat;
      end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = {pend_addr[15:0] ^ 16'hBEEF, 16'hC0DE};
        end
      end
    end
  end

  // Decode monitor: every accepted instruction must match the queue head.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clock);
      if (!reset && bus.dec_valid && bus.dec_ready && !bus.redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dec_unexpected: got pc 0x%08h instr 0x%08h, expected none",
                   bus.dec_pc, bus.dec_instr);
        end else begin
          e = exp_q.pop_front();
          check32("dec_pc", bus.dec_pc, e[63:32]);
          check32("dec_instr", bus.dec_instr, e[31:0]);
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d entries still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset                  = 1'b1;
    bus.redirect_valid     = 1'b0;
    bus.imem_req_ready     = 1'b0;
    bus.dec_ready          = 1'b0;
    tick();
    samp();
    check32("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check32("rst_pc_enable", 32'(bus.pc_enable), 32'd0);
    check32("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    tick();
  endtask

  initial begin
    reset               = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;
    bus.imem_req_ready  = 1'b0;
    bus.dec_ready       = 1'b0;

    // Streaming: 0x0, 0x4, 0x8, one request every two cycles.
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.dec_ready      = 1'b1;
    rsp_lat            = 1;
    exp_q.push_back({32'h0000_0000, 32'hBEEF_C0DE});
    exp_q.push_back({32'h0000_0004, 32'hBEEB_C0DE});
    exp_q.push_back({32'h0000_0008, 32'hBEE7_C0DE});
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      samp();
      check32("stream_req_valid", 32'(bus.imem_req_valid), 32'((i % 2) == 0));
      if ((i % 2) == 0) check32("stream_req_addr", bus.imem_req_addr, 32'(i * 2));
      tick();
    end
    bus.imem_req_ready = 1'b0;
    wait_drain("stream_drain");

    // Decode stalled: FIFO fills with 0x0/0x4, then resumes at 0x8.
    do_reset();
    bus.imem_req_ready = 1'b1;
    exp_q.push_back({32'h0000_0000, 32'hBEEF_C0DE});
    exp_q.push_back({32'h0000_0004, 32'hBEEB_C0DE});
    exp_q.push_back({32'h0000_0008, 32'hBEE7_C0DE});
    reset = 1'b0;
    repeat (4) tick();
    samp();
    check32("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check32("full_dec_valid", 32'(bus.dec_valid), 32'd1);
    check32("full_dec_pc", bus.dec_pc, 32'h0000_0000);
    tick();
    samp();
    check32("full_req_valid_hold", 32'(bus.imem_req_valid), 32'd0);
    tick();
    bus.dec_ready = 1'b1;
    samp();
    check32("full_req_valid_pop", 32'(bus.imem_req_valid), 32'd0);
    tick();
    samp();
    check32("resume_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check32("resume_req_addr", bus.imem_req_addr, 32'h0000_0008);
    tick();
    bus.imem_req_ready = 1'b0;
    wait_drain("full_drain");

    // Redirect to 0x103 while waiting for 0x8; late response is dropped.
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.dec_ready      = 1'b1;
    rsp_lat            = 1;
    exp_q.push_back({32'h0000_0000, 32'hBEEF_C0DE});
    exp_q.push_back({32'h0000_0004, 32'hBEEB_C0DE});
    exp_q.push_back({32'h0000_0100, 32'hBFEF_C0DE});
    reset = 1'b0;
    repeat (4) tick();
    rsp_lat = 3;
    samp();
    check32("drain_req_addr8", bus.imem_req_addr, 32'h0000_0008);
    tick();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0103;
    samp();
    check32("drain_redir_pc_enable", 32'(bus.pc_enable), 32'd1);
    check32("drain_redir_pc_input", bus.pc_input, 32'h0000_0100);
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      samp();
      check32("drain_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check32("drain_dec_valid", 32'(bus.dec_valid), 32'd0);
      tick();
    end
    rsp_lat = 1;
    samp();
    check32("drain_next_valid", 32'(bus.imem_req_valid), 32'd1);
    check32("drain_next_addr", bus.imem_req_addr, 32'h0000_0100);
    tick();
    bus.imem_req_ready = 1'b0;
    wait_drain("redirect_drain");

    // Redirect coincident with a response in WAIT: data dropped, FIFO flushed.
    do_reset();
    bus.imem_req_ready = 1'b1;
    exp_q.push_back({32'h0000_0040, 32'hBEAF_C0DE});
    reset = 1'b0;
    repeat (3) tick();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0040;
    bus.dec_ready       = 1'b1;
    samp();
    check32("coin_dec_valid_pre", 32'(bus.dec_valid), 32'd1);
    check32("coin_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check32("coin_pc_input", bus.pc_input, 32'h0000_0040);
    tick();
    bus.redirect_valid = 1'b0;
    samp();
    check32("coin_dec_valid_flushed", 32'(bus.dec_valid), 32'd0);
    check32("coin_req_valid_next", 32'(bus.imem_req_valid), 32'd1);
    check32("coin_req_addr_next", bus.imem_req_addr, 32'h0000_0040);
    tick();
    bus.imem_req_ready = 1'b0;
    samp();
    check32("idle_pc_enable", 32'(bus.pc_enable), 32'd0);
    check32("idle_pc_input", bus.pc_input, 32'h0000_0044);
    wait_drain("coin_drain");

    // PC wrap: misaligned redirect to the top word, then request at 0xFFFFFFFC.
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFF;
    samp();
    check32("wrap_redir_pc_input", bus.pc_input, 32'hFFFF_FFFC);
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    exp_q.push_back({32'hFFFF_FFFC, 32'h4113_C0DE});
    samp();
    check32("wrap_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    check32("wrap_pc_enable", 32'(bus.pc_enable), 32'd1);
    check32("wrap_pc_input", bus.pc_input, 32'h0000_0000);
    tick();
    bus.imem_req_ready = 1'b0;
    samp();
    check32("wrap_wait_pc_enable", 32'(bus.pc_enable), 32'd0);
    tick();
    wait_drain("wrap_drain");

    // Reset while in DRAIN; stray response after reset must be ignored.
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0200;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    rsp_lat            = 3;
    samp();
    check32("rd_req_addr", bus.imem_req_addr, 32'h0000_0200);
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0300;
    tick();
    bus.redirect_valid = 1'b0;
    reset              = 1'b1;
    samp();
    check32("rd_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check32("rd_rst_pc_enable", 32'(bus.pc_enable), 32'd0);
    tick();
    reset              = 1'b0;
    rsp_lat            = 1;
    bus.imem_req_ready = 1'b1;
    exp_q.push_back({32'h0000_0000, 32'hBEEF_C0DE});
    samp();
    check32("rd_first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check32("rd_first_req_addr", bus.imem_req_addr, 32'h0000_0000);
    check32("rd_dec_valid", 32'(bus.dec_valid), 32'd0);
    tick();
    bus.imem_req_ready = 1'b0;
    samp();
    check32("rd_stray_dropped", 32'(bus.dec_valid), 32'd0);
    tick();
    wait_drain("rd_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
